// File: rtl/bos_pkg.sv
// Shared types for the BOS serial-video return path: SPI FSM states, byte phases, frame marker bytes.
// Holds no logic apart from the byte-phase successor function.
package bos_pkg;

    localparam logic [7:0] MARKER_HI = 8'hA5;
    localparam logic [7:0] MARKER_LO = 8'h5A;

    typedef enum logic [2:0] {
        SPI_IDLE,
        SPI_SETUP,
        SPI_SHIFT,
        SPI_HOLD,
        SPI_GAP
    } spi_state_t;

    typedef enum logic [1:0] {
        MARK_HI,
        MARK_LO,
        HIGH,
        LOW
    } byte_phase_t;

    // A marker pair always runs straight into the high byte of its word.
    function automatic byte_phase_t next_phase(input byte_phase_t p);
        case (p)
            MARK_HI: next_phase = MARK_LO;
            MARK_LO: next_phase = HIGH;
            HIGH:    next_phase = LOW;
            default: next_phase = HIGH;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo_w.sv
// Single-clock word FIFO with a registered read port (data valid the cycle after i_rd).
// Latency 1 cycle write-to-not-empty; a write to a full FIFO is accepted only alongside a read.
module sync_fifo_w #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rd_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_usedw
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;
    logic [WIDTH-1:0] r_rd_dat;
    logic             w_rd_ok;
    logic             w_wr_ok;

    assign o_full   = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty  = (r_cnt == '0);
    assign o_usedw  = r_cnt;
    assign o_rd_dat = r_rd_dat;

    // A read in the same cycle frees the slot, so a full FIFO can still take the write.
    assign w_rd_ok = i_rd & ~o_empty;
    assign w_wr_ok = i_wr & (~o_full | w_rd_ok);

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_rd_dat <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_dat <= r_mem[r_rptr];
                r_rptr   <= r_rptr + AW'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/video_spi_capture.sv
// SPI master capturing WORD_BITS-bit video samples, buffered and sent to the PC link as HIGH/LOW bytes.
// Latency: word pushed at cycle N is presented at N+2; bytes hold stable while tx_ready=0, words back up in the FIFO.
// FRAME_MARKER_EN: when defined, an A5/5A marker pair precedes the first word and every FRAME_LEN-th word after it.
module video_spi_capture
    import bos_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int WORD_BITS  = 12,
    parameter int GAP_CYCLES = 4,
    parameter int FIFO_AW    = 4,
    parameter int FRAME_LEN  = 256
) (
    input  logic               sys_clk,
    input  logic               n_rst,
    input  logic               capture_en,
    output logic               slv_fpga,
    output logic               sckv_fpga,
    input  logic               sdatav_fpga,
    output logic [7:0]         data_to_pc,
    output logic               tx_ena,
    input  logic               tx_ready,
    output logic               overflow,
    output logic [FIFO_AW:0]   words_stored
);

`ifdef FRAME_MARKER_EN
    localparam bit MARK_EN = 1'b1;
`else
    localparam bit MARK_EN = 1'b0;
`endif

    localparam int DIV_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int DIV_W   = $clog2(DIV_MAX) + 1;
    localparam int HALF_W  = $clog2(2 * WORD_BITS) + 1;
    localparam int FRM_W   = $clog2(FRAME_LEN) + 1;

    spi_state_t             r_state;
    spi_state_t             w_state_nxt;
    logic [DIV_W-1:0]       r_cnt;
    logic [HALF_W-1:0]      r_half;
    logic [WORD_BITS-1:0]   r_shift;
    logic                   r_cap_d;
    logic                   r_ovf;
    logic                   r_vld;
    byte_phase_t            r_phase;
    logic [FRM_W-1:0]       r_frm_cnt;

    logic                   w_div_done;
    logic                   w_gap_done;
    logic                   w_last_half;
    logic                   w_push;
    logic                   w_cap_rise;
    logic [15:0]            w_word;
    logic                   w_full;
    logic                   w_empty;
    logic [FIFO_AW:0]       w_usedw;
    logic                   w_acc;
    logic                   w_word_done;
    logic                   w_pop;
    byte_phase_t            w_first_phase;

    assign w_div_done  = (r_cnt == DIV_W'(CLK_DIV - 1));
    assign w_gap_done  = (r_cnt == DIV_W'(GAP_CYCLES - 1));
    assign w_last_half = (r_half == HALF_W'(2 * WORD_BITS - 1));
    assign w_cap_rise  = capture_en & ~r_cap_d;

    // SPI FSM: state register
    always_ff @(posedge sys_clk) begin
        if (!n_rst) begin
            r_state <= SPI_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // SPI FSM: next state; capture_en is only consulted between words
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SPI_IDLE:  if (capture_en)                 w_state_nxt = SPI_SETUP;
            SPI_SETUP: if (w_div_done)                 w_state_nxt = SPI_SHIFT;
            SPI_SHIFT: if (w_div_done && w_last_half)  w_state_nxt = SPI_HOLD;
            SPI_HOLD:  if (w_div_done)                 w_state_nxt = SPI_GAP;
            SPI_GAP:   if (w_gap_done)                 w_state_nxt = capture_en ? SPI_SETUP : SPI_IDLE;
            default:                                   w_state_nxt = SPI_IDLE;
        endcase
    end

    // SPI FSM: outputs; odd half-periods of SHIFT are the high phase of sckv_fpga
    always_comb begin
        slv_fpga  = (r_state == SPI_IDLE) || (r_state == SPI_GAP);
        sckv_fpga = (r_state == SPI_SHIFT) && r_half[0];
        w_push    = (r_state == SPI_HOLD) && w_div_done;
    end

    always_ff @(posedge sys_clk) begin
        if (!n_rst) begin
            r_cnt   <= '0;
            r_half  <= '0;
            r_shift <= '0;
        end else begin
            if ((w_state_nxt != r_state) || ((r_state == SPI_SHIFT) && w_div_done)) begin
                r_cnt <= '0;
            end else if (r_state != SPI_IDLE) begin
                r_cnt <= r_cnt + DIV_W'(1);
            end

            if (w_state_nxt != SPI_SHIFT) begin
                r_half <= '0;
            end else if ((r_state == SPI_SHIFT) && w_div_done) begin
                r_half <= r_half + HALF_W'(1);
            end

            // Sample on the edge where sckv_fpga goes high
            if ((r_state == SPI_SHIFT) && w_div_done && !r_half[0]) begin
                r_shift <= (r_shift << 1) | WORD_BITS'(sdatav_fpga);
            end
        end
    end

    sync_fifo_w #(
        .WIDTH (16),
        .AW    (FIFO_AW)
    ) u_fifo (
        .i_clk    (sys_clk),
        .i_rst_n  (n_rst),
        .i_wr     (w_push),
        .i_wr_dat (16'(r_shift)),
        .i_rd     (w_pop),
        .o_rd_dat (w_word),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_usedw  (w_usedw)
    );

    always_ff @(posedge sys_clk) begin
        if (!n_rst) begin
            r_cap_d <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_cap_d <= capture_en;
            if (w_cap_rise) begin
                r_ovf <= 1'b0;
            end else if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // The FIFO read register is the unpacker's word register. Words are only
    // popped while the link is ready, so a stalled link leaves the backlog in
    // the FIFO where occupancy and overflow account for it.
    assign w_acc       = r_vld & tx_ready;
    assign w_word_done = w_acc & (r_phase == LOW);
    assign w_pop       = ~w_empty & tx_ready & (~r_vld | w_word_done);

    assign w_first_phase = (MARK_EN && (r_frm_cnt == '0)) ? MARK_HI : HIGH;

    always_ff @(posedge sys_clk) begin
        if (!n_rst) begin
            r_vld     <= 1'b0;
            r_phase   <= HIGH;
            r_frm_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_vld   <= 1'b1;
                r_phase <= w_first_phase;
            end else if (w_word_done) begin
                r_vld   <= 1'b0;
            end else if (w_acc) begin
                r_phase <= next_phase(r_phase);
            end

            if (w_cap_rise) begin
                r_frm_cnt <= '0;
            end else if (w_pop) begin
                r_frm_cnt <= (r_frm_cnt == FRM_W'(FRAME_LEN - 1)) ? '0 : r_frm_cnt + FRM_W'(1);
            end
        end
    end

    always_comb begin
        data_to_pc = '0;
        if (r_vld) begin
            case (r_phase)
                MARK_HI: data_to_pc = MARKER_HI;
                MARK_LO: data_to_pc = MARKER_LO;
                HIGH:    data_to_pc = w_word[15:8];
                default: data_to_pc = w_word[7:0];
            endcase
        end
    end

    assign tx_ena       = r_vld;
    assign overflow     = r_ovf;
    assign words_stored = w_usedw;

endmodule
